if_stage: RTL and testbench

Instruction fetch stage sitting directly upstream of the instruction decoders (I-type, R-type, etc.), which take a 32-bit inst and produce the control bundle.
- Owns the PC and issues single-outstanding requests to instruction memory.
- Buffers responses in a 2-entry {pc, inst} queue.
- Presents the queue head to decode with a valid/ready handshake.
- Accepts redirects (branch/jump, npc_sel path) that flush the queue and kill in-flight fetches.

---
 rtl/if_stage.sv | 160 ++++++++++++++++
 tb/tb_if_stage.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | if_stage: instruction fetch with one request outstanding at a time,  |
// | feeding a 2-entry {pc, inst} queue to decode. Option: IF_MISALIGN_CHECK_EN |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module if_stage #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] PC_RESET = '0,
  parameter int              QDEPTH   = 2
) (
  input  logic            clk,
  input  logic            rstn,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            dec_ready,
  output logic            inst_valid,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc
`ifdef IF_MISALIGN_CHECK_EN
  ,
  output logic            fetch_misalign
`endif
);

  localparam logic [1:0]  S_RUN    = 2'd0;
  localparam logic [1:0]  S_WAIT   = 2'd1;
  localparam logic [1:0]  S_KILL   = 2'd2;
  localparam logic [1:0]  c_QDEPTH = 2'(QDEPTH);
  localparam logic [31:0] c_NOP    = 32'h0000_0013;

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_tag;
  logic [1:0]      r_count;
  logic [XLEN-1:0] r_q0_pc;
  logic [XLEN-1:0] r_q1_pc;
  logic [31:0]     r_q0_inst;
  logic [31:0]     r_q1_inst;

  logic            w_req_valid;
  logic            w_accept;
  logic            w_push;
  logic            w_pop;
  logic [1:0]      w_cnt_after_pop;
  logic [XLEN-1:0] w_redir_pc;
  logic            w_mis_block;

`ifdef IF_MISALIGN_CHECK_EN
  logic r_misalign;

  // A misaligned target is still loaded so a later aligned redirect is the only way out.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_misalign <= 1'b0;
    end else if (redirect_valid) begin
      r_misalign <= (redirect_pc[1:0] != 2'b00);
    end
  end

  assign w_redir_pc     = redirect_pc;
  assign w_mis_block    = r_misalign;
  assign fetch_misalign = r_misalign;
`else
  logic w_unused_lsbs;
  assign w_unused_lsbs = ^redirect_pc[1:0];
  assign w_redir_pc    = {redirect_pc[XLEN-1:2], 2'b00};
  assign w_mis_block   = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: a response always retires the outstanding fetch, kept or not
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN: begin
        if (w_accept) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (imem_resp_valid)     w_state_nxt = S_RUN;
        else if (redirect_valid) w_state_nxt = S_KILL;
      end
      S_KILL: begin
        if (imem_resp_valid) w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  // Outputs: request issue
  always_comb begin
    w_req_valid = 1'b0;
    if (rstn && (r_state == S_RUN) && !redirect_valid && !w_mis_block &&
        (r_count < c_QDEPTH)) begin
      w_req_valid = 1'b1;
    end
  end

  assign imem_req_valid  = w_req_valid;
  assign imem_req_addr   = r_pc;
  assign w_accept        = w_req_valid && imem_req_ready;
  assign w_push          = (r_state == S_WAIT) && imem_resp_valid && !redirect_valid;
  assign w_pop           = inst_valid && dec_ready && !redirect_valid;
  assign w_cnt_after_pop = r_count - 2'(w_pop);

  assign inst_valid = (r_count != 2'd0);
  assign inst       = inst_valid ? r_q0_inst : c_NOP;
  assign inst_pc    = inst_valid ? r_q0_pc : '0;

  // Entry 0 is always the head; a pop shifts entry 1 down before the push lands.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_pc      <= PC_RESET;
      r_tag     <= '0;
      r_count   <= 2'd0;
      r_q0_pc   <= '0;
      r_q1_pc   <= '0;
      r_q0_inst <= c_NOP;
      r_q1_inst <= c_NOP;
    end else if (redirect_valid) begin
      r_pc    <= w_redir_pc;
      r_count <= 2'd0;
    end else begin
      if (w_accept) begin
        r_pc  <= r_pc + XLEN'(4);
        r_tag <= r_pc;
      end
      if (w_pop) begin
        r_q0_pc   <= r_q1_pc;
        r_q0_inst <= r_q1_inst;
      end
      if (w_push) begin
        if (w_cnt_after_pop == 2'd0) begin
          r_q0_pc   <= r_tag;
          r_q0_inst <= imem_resp_data;
        end else begin
          r_q1_pc   <= r_tag;
          r_q1_inst <= imem_resp_data;
        end
      end
      r_count <= r_count + 2'(w_push) - 2'(w_pop);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_if_stage: randomized bench for if_stage against a queue model.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_if_stage;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] ins;
  } ent_t;

  logic        clk;
  logic        rstn;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        dec_ready;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_pc;
`ifdef IF_MISALIGN_CHECK_EN
  logic        fetch_misalign;
`endif

  int checks = 0;
  int errors = 0;

  if_stage #(.XLEN(64), .PC_RESET(64'h1000), .QDEPTH(2)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .dec_ready       (dec_ready),
    .inst_valid      (inst_valid),
    .inst            (inst),
    .inst_pc         (inst_pc)
`ifdef IF_MISALIGN_CHECK_EN
    ,
    .fetch_misalign  (fetch_misalign)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [63:0] a);
    return a[31:0] ^ 32'hCAFE_0000;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: fetch bookkeeping in terms of "one fetch in flight, maybe doomed"
  ent_t        mq[$];
  logic [63:0] m_pc;
  logic [63:0] m_tag;
  bit          m_out;
  bit          m_kill;
  bit          m_mis;
  bit          m_init = 0;

  always @(negedge clk) begin
    bit          e_req;
    bit          acc;
    logic [63:0] rp;
    e_req = rstn && !m_out && !redirect_valid && (mq.size() < 2) && !m_mis;
    if (m_init) begin
      chk("req_valid", 64'(imem_req_valid), 64'(e_req));
      chk("req_addr", imem_req_addr, m_pc);
      chk("inst_valid", 64'(inst_valid), 64'(mq.size() > 0));
      chk("inst", 64'(inst), 64'((mq.size() > 0) ? mq[0].ins : 32'h13));
      chk("inst_pc", inst_pc, (mq.size() > 0) ? mq[0].pc : 64'h0);
`ifdef IF_MISALIGN_CHECK_EN
      chk("fetch_misalign", 64'(fetch_misalign), 64'(m_mis));
`endif
    end
    if (!rstn) begin
      mq.delete();
      m_pc = 64'h1000; m_tag = '0; m_out = 0; m_kill = 0; m_mis = 0;
      m_init = 1;
    end else if (m_init) begin
      acc = e_req && imem_req_ready;
      if (redirect_valid) begin
        mq.delete();
        rp = redirect_pc;
`ifdef IF_MISALIGN_CHECK_EN
        m_mis = (rp[1:0] != 2'b00);
        m_pc  = rp;
`else
        m_pc  = {rp[63:2], 2'b00};
`endif
        if (imem_resp_valid) m_out = 0;
        else if (m_out)      m_kill = 1;
      end else begin
        if ((mq.size() > 0) && dec_ready) void'(mq.pop_front());
        if (imem_resp_valid && m_out) begin
          if (!m_kill) mq.push_back('{pc: m_tag, ins: imem_resp_data});
          m_out = 0;
        end
        if (acc) begin
          m_out = 1; m_kill = 0; m_tag = m_pc; m_pc = m_pc + 64'd4;
        end
      end
    end
  end

  // Memory / decoder / redirect environment
  bit          mem_pend = 0;
  logic [63:0] mem_addr;
  int          mem_dly;
  int          dly_max = 0;
  int          p_ready = 100;
  int          p_dec   = 100;
  int          p_redir = 0;
  logic [63:0] acc_log[$];

  task automatic tick();
    logic [63:0] rp;
    @(negedge clk);
    if (!rstn) begin
      mem_pend = 0;
    end else begin
      if (imem_resp_valid) mem_pend = 0;
      if (imem_req_valid && imem_req_ready) begin
        mem_pend = 1;
        mem_addr = imem_req_addr;
        mem_dly  = $urandom_range(0, dly_max);
        if (acc_log.size() < 8) acc_log.push_back(imem_req_addr);
      end
    end
    @(posedge clk);
    #1;
    imem_resp_valid = 1'b0;
    if (mem_pend) begin
      if (mem_dly == 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = memf(mem_addr);
      end else begin
        mem_dly--;
      end
    end
    imem_req_ready = ($urandom_range(0, 99) < p_ready);
    dec_ready      = ($urandom_range(0, 99) < p_dec);
    redirect_valid = ($urandom_range(0, 99) < p_redir);
    if ($urandom_range(0, 9) == 0) rp = 64'hFFFF_FFFF_FFFF_FFF8;
    else                           rp = 64'h2000 + 64'($urandom_range(0, 1023)) * 64'd4;
    if ($urandom_range(0, 4) == 0) rp[1:0] = 2'($urandom_range(1, 3));
    redirect_pc = rp;
  endtask

  task automatic chk_reset_outputs();
    chk("rst req_valid", 64'(imem_req_valid), 64'h0);
    chk("rst inst_valid", 64'(inst_valid), 64'h0);
    chk("rst inst", 64'(inst), 64'h13);
    chk("rst inst_pc", inst_pc, 64'h0);
    chk("rst req_addr", imem_req_addr, 64'h1000);
  endtask

  initial begin
    bit seen;
    rstn = 1'b0;
    imem_req_ready = 0; imem_resp_valid = 0; imem_resp_data = '0;
    redirect_valid = 0; redirect_pc = '0; dec_ready = 0;

    repeat (3) tick();
    chk_reset_outputs();
    rstn = 1'b1;

    // Ideal memory, always-ready decode: fetch order and first head
    seen = 0;
    repeat (12) begin
      tick();
      if (!seen && inst_valid) begin
        seen = 1;
        chk("first inst_pc", inst_pc, 64'h1000);
        chk("first inst", 64'(inst), 64'hCAFE_1000);
      end
    end
    chk("first head seen", 64'(seen), 64'h1);
    if (acc_log.size() >= 3) begin
      chk("fetch0", acc_log[0], 64'h1000);
      chk("fetch1", acc_log[1], 64'h1004);
      chk("fetch2", acc_log[2], 64'h1008);
    end else begin
      chk("fetch count", 64'(acc_log.size()), 64'd3);
    end

    // Decode stall fills the queue and holds off fetch
    p_dec = 0;
    repeat (10) tick();
    chk("full req_valid", 64'(imem_req_valid), 64'h0);
    chk("full inst_valid", 64'(inst_valid), 64'h1);
    p_dec = 100;

    // Directed redirect: the next fetch goes to the new target
    tick();
    acc_log.delete();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h2000;
    for (int i = 0; i < 20 && acc_log.size() == 0; i++) tick();
    if (acc_log.size() > 0) chk("redirect fetch", acc_log[0], 64'h2000);
    else                    chk("redirect fetch timeout", 64'h0, 64'h1);

    // Randomized traffic with periodic decode stall bursts
    p_ready = 70; p_redir = 6; dly_max = 2;
    for (int i = 0; i < 4000; i++) begin
      p_dec = ((i / 200) % 2 == 0) ? 60 : 5;
      tick();
    end

    // Reset in the middle of traffic
    rstn = 1'b0;
    repeat (2) tick();
    chk_reset_outputs();
    rstn = 1'b1;
    p_dec = 60;
    repeat (300) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
